// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg: shared constants, controller states and op helpers
// for the ALU command driver and its command FIFO.
package alu_drv_pkg;

  localparam int W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_t;

  function automatic logic is_supported(
    input logic [2:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: small synchronous FIFO holding packed commands
// between the request stream and the ALU controller.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is data only; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: buffers ALU commands, drives the combinational
// ALU for a settle time and returns results in command order.
module alu_cmd_driver #(
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_chain,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic         res_err
);

  import alu_drv_pkg::*;

  localparam int EW = 2*W + 4;
  localparam int CW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(SETTLE_CYC - 1);

  state_t state_q;
  state_t state_d;

  logic [EW-1:0] fifo_din;
  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          cmd_push;

  logic [W-1:0]  head_a;
  logic [W-1:0]  head_b;
  logic [2:0]    head_op;
  logic          head_chain;

  logic          res_hs;
  logic          load;
  logic          ld_sup;
  logic          capture;

  logic [W-1:0]  acc_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  alu_a_d;
  logic [W-1:0]  alu_b_d;
  logic [2:0]    alu_sel_d;
  logic [W-1:0]  res_y_d;
  logic          res_err_d;
  logic          res_valid_d;
  logic [W-1:0]  acc_d;
  logic [CW-1:0] cnt_d;

  assign cmd_ready = !rst && !fifo_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign fifo_din  = {cmd_a, cmd_b, cmd_op, cmd_chain};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .din   (fifo_din),
    .pop   (load),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a     = head[EW-1 -: W];
  assign head_b     = head[W+3 -: W];
  assign head_op    = head[3:1];
  assign head_chain = head[0];

  // RESP always has res_valid set, so ready alone completes it.
  assign res_hs  = (state_q == RESP) && res_ready;
  assign load    = !fifo_empty &&
                   ((state_q == IDLE) || res_hs);
  assign ld_sup  = is_supported(head_op);
  assign capture = (state_q == DRIVE) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a load decides between settling and an error reply.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load) state_d = ld_sup ? DRIVE : RESP;
      end
      DRIVE: begin
        if (capture) state_d = RESP;
      end
      RESP: begin
        if (res_hs) begin
          if (load) state_d = ld_sup ? DRIVE : RESP;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: load, capture, countdown and release.
  always_comb begin
    alu_a_d     = alu_a;
    alu_b_d     = alu_b;
    alu_sel_d   = alu_sel;
    res_y_d     = res_y;
    res_err_d   = res_err;
    res_valid_d = res_valid;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (res_hs) res_valid_d = 1'b0;
    if (load) begin
      alu_a_d   = head_chain ? acc_q : head_a;
      alu_b_d   = head_b;
      alu_sel_d = head_op;
      cnt_d     = CNT_INIT;
      if (!ld_sup) begin
        res_y_d     = '0;
        res_err_d   = 1'b1;
        res_valid_d = 1'b1;
      end
    end else if (capture) begin
      res_y_d     = alu_y;
      acc_d       = alu_y;
      res_err_d   = 1'b0;
      res_valid_d = 1'b1;
    end else if (state_q == DRIVE) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Output and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_y     <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_sel   <= alu_sel_d;
      res_y     <= res_y_d;
      res_err   <= res_err_d;
      res_valid <= res_valid_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed vectors and multi-cycle sequences
// for alu_cmd_driver with a behavioural 8-bit add/sub ALU.
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_y;
  logic       res_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign alu_y = (alu_sel == 3'b000) ? alu_a + alu_b :
                 (alu_sel == 3'b001) ? alu_a - alu_b :
                 8'hA5;

  alu_cmd_driver #(
    .DEPTH      (4),
    .SETTLE_CYC (1),
    .W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_chain (cmd_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_err   (res_err)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       chain;
    logic [7:0] exp_a;
    logic [7:0] exp_y;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [2:0] op,
                      input logic       chain);
    int n = 0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_chain = chain;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    push(v.a, v.b, v.op, v.chain);
    @(negedge clk);
    check($sformatf("v%0d_alu_a", idx), 32'(alu_a),
          32'(v.exp_a));
    check($sformatf("v%0d_alu_b", idx), 32'(alu_b),
          32'(v.b));
    check($sformatf("v%0d_alu_sel", idx), 32'(alu_sel),
          32'(v.op));
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 32'(lat),
          32'(v.exp_lat));
    check($sformatf("v%0d_res_y", idx), 32'(res_y),
          32'(v.exp_y));
    check($sformatf("v%0d_res_err", idx), 32'(res_err),
          32'(v.exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   got;
    int   n;
    logic sent;

    vecs[0]  = '{8'h05, 8'h03, 3'b000, 1'b0,
                 8'h05, 8'h08, 1'b0, 2};
    vecs[1]  = '{8'h02, 8'h05, 3'b001, 1'b0,
                 8'h02, 8'hFD, 1'b0, 2};
    vecs[2]  = '{8'h0A, 8'h14, 3'b000, 1'b0,
                 8'h0A, 8'h1E, 1'b0, 2};
    vecs[3]  = '{8'hFF, 8'h0E, 3'b001, 1'b1,
                 8'h1E, 8'h10, 1'b0, 2};
    vecs[4]  = '{8'h33, 8'h11, 3'b010, 1'b0,
                 8'h33, 8'h00, 1'b1, 1};
    vecs[5]  = '{8'h77, 8'h01, 3'b000, 1'b1,
                 8'h10, 8'h11, 1'b0, 2};
    vecs[6]  = '{8'h5A, 8'hC3, 3'b111, 1'b0,
                 8'h5A, 8'h00, 1'b1, 1};
    vecs[7]  = '{8'hFF, 8'h01, 3'b000, 1'b0,
                 8'hFF, 8'h00, 1'b0, 2};
    vecs[8]  = '{8'h12, 8'h01, 3'b001, 1'b1,
                 8'h00, 8'hFF, 1'b0, 2};
    vecs[9]  = '{8'h40, 8'hC0, 3'b001, 1'b0,
                 8'h40, 8'h80, 1'b0, 2};
    vecs[10] = '{8'h99, 8'h07, 3'b000, 1'b1,
                 8'h00, 8'h07, 1'b0, 2};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    cmd_chain = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_alu_sel", 32'(alu_sel), 32'h0);
    check("rst_res_y", 32'(res_y), 32'h0);
    check("rst_res_err", 32'(res_err), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    @(negedge clk);

    // FIFO full with the consumer stalled.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(8'(i), 8'h01, 3'b000, 1'b0);
    cmd_a     = 8'h05;
    cmd_b     = 8'h01;
    cmd_op    = 3'b000;
    cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_cmd_ready", 32'(cmd_ready), 32'h0);
    end
    check("stall_res_valid", 32'(res_valid), 32'h1);
    check("stall_res_y", 32'(res_y), 32'h01);
    res_ready = 1'b1;
    got  = 0;
    n    = 0;
    sent = 1'b0;
    while (got < 6 && n < 60) begin
      if (res_valid) begin
        check($sformatf("order_y%0d", got), 32'(res_y),
              32'(got + 1));
        check($sformatf("order_err%0d", got),
              32'(res_err), 32'h0);
        got++;
      end
      if (cmd_valid && cmd_ready) sent = 1'b1;
      @(negedge clk);
      n++;
      if (sent) cmd_valid = 1'b0;
    end
    check("order_count", 32'(got), 32'd6);
    check("sixth_accepted", 32'(sent), 32'h1);

    // Reset while driving with three commands buffered.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(8'h40 + 8'(i), 8'h01, 3'b000, 1'b0);
    check("b_cmd_ready", 32'(cmd_ready), 32'h1);
    check("b_res_y", 32'(res_y), 32'h41);
    res_ready = 1'b1;
    cmd_a     = 8'h44;
    cmd_b     = 8'h01;
    cmd_op    = 3'b000;
    cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check("b_drive_alu_a", 32'(alu_a), 32'h41);
    check("b_drive_res_valid", 32'(res_valid), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_alu_a", 32'(alu_a), 32'h0);
    check("mid_rst_alu_b", 32'(alu_b), 32'h0);
    check("mid_rst_alu_sel", 32'(alu_sel), 32'h0);
    check("mid_rst_res_y", 32'(res_y), 32'h0);
    check("mid_rst_res_err", 32'(res_err), 32'h0);
    check("mid_rst_res_valid", 32'(res_valid), 32'h0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("mid_rst_cmd_ready_hi", 32'(cmd_ready), 32'h1);
    res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_result", 32'(res_valid), 32'h0);
    end
    run_vec(10, vecs[10]);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator-side controller for the team's 8-bit combinational ALU (sel 000 = add, sel 001 = sub).
- Accepts operation commands on a valid/ready stream and buffers them in a small FIFO.
- Drives the operands and sel to the ALU and holds them for a programmable settle time.
- Captures the ALU result and returns it in order on a valid/ready response stream.
- Supports chained operations: operand A is taken from the previous result.

Parameters:
DEPTH, 4, command FIFO entries (power of two, ≥2)
SETTLE_CYC, 1, cycles alu_a/alu_b/alu_sel are held before alu_y is sampled (≥1)
W, 8, operand/result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_a  in  W  operand A
cmd_b  in  W  operand B
cmd_op  in  3  ALU select code
cmd_chain  in  1  use last result as A (cmd_a ignored)
alu_a  out  W  to ALU a
alu_b  out  W  to ALU b
alu_sel  out  3  to ALU sel
alu_y  in  W  from ALU y (combinational)
res_valid  out  1  result present
res_ready  in  1  consumer accepts
res_y  out  W  captured result
res_err  out  1  op code unsupported

Behaviour:
- Reset values: alu_a, alu_b, alu_sel, res_y and res_err = 0; res_valid = 0; acc = 0; FIFO empty; state IDLE. cmd_ready = 0 while rst is high.
- cmd_ready = !rst && FIFO not full.
- Push on cmd_valid && cmd_ready; the entry is {a, b, op, chain}.
- A push and a pop in the same cycle are legal. The count is unchanged and the pointers wrap modulo DEPTH.
- States: IDLE, DRIVE, RESP.
- IDLE: if the FIFO is non-empty, pop the head and register the operands.
  - alu_a = chain ? acc : a.
  - alu_b = b; alu_sel = op.
  - Supported op (000/001): cnt = SETTLE_CYC-1, go to DRIVE.
  - Unsupported op (010–111): res_y = 0, res_err = 1, res_valid = 1, go to RESP. The ALU is not sampled.
- DRIVE: decrement cnt each cycle. At the edge where cnt == 0:
  - res_y = alu_y; acc = alu_y; res_err = 0; res_valid = 1.
  - Go to RESP.
- RESP: hold res_y, res_err and res_valid until res_ready is high.
  - On the handshake edge, res_valid = 0.
  - If the FIFO is non-empty, pop and load the next command on the same edge (back-to-back). Otherwise go to IDLE.
- alu_a, alu_b and alu_sel stay stable from load until the next load. They are never changed in DRIVE.
- Latency with SETTLE_CYC=1: accept at edge N, pop/drive at N+1, res_valid high after N+2. Each additional settle cycle adds 1.
- Throughput: one result per SETTLE_CYC+1 cycles when res_ready is held high.
- Arithmetic: the block performs none. It forwards W-bit values and captures alu_y as-is; add/sub wrap modulo 2^W in the ALU.
- Unsupported ops never update acc.
- A chained command with no prior result uses acc = 0.
- Full FIFO: cmd_ready is low and no push occurs. Commands already buffered are unaffected.
- Ordering: results are strictly in command order.
- Reset mid-operation: state, FIFO, acc and all outputs return to reset values on the next edge. No pending result is emitted.

Decomposition:
- Package alu_drv_pkg:
  - Constants OP_ADD=3'b000, OP_SUB=3'b001 and W.
  - State enum {IDLE, DRIVE, RESP}.
  - Function is_supported(op).
- Sub-module alu_cmd_fifo:
  - Parameterised by DEPTH and entry width.
  - Synchronous rst, push/pop, full/empty.
- The controller and output registers live in alu_cmd_driver.

Test Plan:
- Reset, then cmd a=8'h05, b=8'h03, op=000 (SETTLE_CYC=1) -> alu_a=05/alu_b=03/alu_sel=000 one cycle after accept; res_valid high 2 cycles after accept with res_y=8'h08, res_err=0.
- a=8'h02, b=8'h05, op=001 -> res_y=8'hFD, res_err=0 (wrap).
- Add a=8'h0A, b=8'h14 -> 8'h1E; then cmd_chain=1, b=8'h0E, op=001, cmd_a=8'hFF -> alu_a=8'h1E, res_y=8'h10.
- op=010, a=8'h33, b=8'h11 -> res_y=8'h00, res_err=1, acc unchanged; following chain add b=8'h01 -> res_y=8'h11.
- res_ready held 0, issue 6 adds (a=i, b=1, i=0..5) with DEPTH=4 -> 5 accepted (1 in flight plus 4 buffered), cmd_ready low. Release res_ready -> results 01,02,03,04,05 in order, then the 6th accepted and returns 06.
- Assert rst for 1 cycle during DRIVE with 3 entries buffered -> next cycle all outputs 0, res_valid=0, cmd_ready=1 after rst drops; a chained add b=8'h07 then yields 8'h07.
